// File: rtl/hood_mode_sequencer_if.sv
// Key/power inputs and mode/fan/display outputs of the range-hood mode sequencer.
// master = power/gesture controller side, slave = the sequencer.
interface hood_mode_sequencer_if;
  logic       power_on;
  logic       menu_key;
  logic       level1_key;
  logic       level2_key;
  logic       level3_key;
  logic       clean_key;
  logic [2:0] mode;
  logic [1:0] fan_level;
  logic       clean_active;
  logic [7:0] remaining_s;
  logic       hurricane_used;
  logic       busy;

  modport master (
    output power_on, menu_key, level1_key, level2_key, level3_key, clean_key,
    input  mode, fan_level, clean_active, remaining_s, hurricane_used, busy
  );

  modport slave (
    input  power_on, menu_key, level1_key, level2_key, level3_key, clean_key,
    output mode, fan_level, clean_active, remaining_s, hurricane_used, busy
  );
endinterface

// File: rtl/hood_mode_sequencer.sv
// Range-hood fan / self-clean mode FSM with a 1 s timebase for the timed modes
// (hurricane, cooldown, self-clean). All outputs are registered.
module hood_mode_sequencer #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned HURRICANE_S = 60,
  parameter int unsigned COOLDOWN_S  = 60,
  parameter int unsigned CLEAN_S     = 180
) (
  input logic                 clk,
  input logic                 reset,
  hood_mode_sequencer_if.slave bus
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  typedef enum logic [2:0] {
    StOff      = 3'd0,
    StStandby  = 3'd1,
    StL1       = 3'd2,
    StL2       = 3'd3,
    StL3       = 3'd4,
    StCooldown = 3'd5,
    StClean    = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    rem_q, rem_d;
  logic          hused_q, hused_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    fan_q, fan_d;
  logic          clean_q, clean_d;
  logic          busy_q, busy_d;
  logic          tick;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StOff;
      rem_q   <= '0;
      hused_q <= 1'b0;
      presc_q <= '0;
      fan_q   <= '0;
      clean_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      hused_q <= hused_d;
      presc_q <= presc_d;
      fan_q   <= fan_d;
      clean_q <= clean_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    hused_d = hused_q;
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + PW'(1);

    if (!bus.power_on) begin
      state_d = StOff;
      rem_d   = '0;
      hused_d = 1'b0;
    end else begin
      case (state_q)
        StOff: state_d = StStandby;
        StStandby: begin
          // menu outranks every other key but has no effect here
          if (!bus.menu_key) begin
            if (bus.level3_key) begin
              if (!hused_q) state_d = StL3;
            end else if (bus.level2_key) begin
              state_d = StL2;
            end else if (bus.level1_key) begin
              state_d = StL1;
            end else if (bus.clean_key) begin
              state_d = StClean;
            end
          end
        end
        StL1, StL2: begin
          if (bus.menu_key) begin
            state_d = StStandby;
          end else if (bus.level3_key) begin
            if (!hused_q) state_d = StL3;
          end else if (bus.level2_key) begin
            state_d = StL2;
          end else if (bus.level1_key) begin
            state_d = StL1;
          end
        end
        StL3: begin
          if (bus.menu_key) begin
            state_d = StCooldown;
          end else if (tick) begin
            if (rem_q <= 8'd1) begin
              state_d = StL2;
              rem_d   = '0;
            end else begin
              rem_d = rem_q - 8'd1;
            end
          end
        end
        StCooldown, StClean: begin
          if (tick) begin
            if (rem_q <= 8'd1) begin
              state_d = StStandby;
              rem_d   = '0;
            end else begin
              rem_d = rem_q - 8'd1;
            end
          end
        end
        default: begin
          state_d = StOff;
          rem_d   = '0;
        end
      endcase

      // Entry into a timed state reloads its duration and restarts the 1 s phase
      if (state_d != state_q) begin
        case (state_d)
          StL3: begin
            rem_d   = 8'(HURRICANE_S);
            hused_d = 1'b1;
            presc_d = '0;
          end
          StCooldown: begin
            rem_d   = 8'(COOLDOWN_S);
            presc_d = '0;
          end
          StClean: begin
            rem_d   = 8'(CLEAN_S);
            presc_d = '0;
          end
          default: ;
        endcase
      end
    end
  end

  // Output decode of the upcoming state, registered alongside it
  always_comb begin
    fan_d   = 2'd0;
    clean_d = 1'b0;
    busy_d  = 1'b0;
    case (state_d)
      StL1:       fan_d = 2'd1;
      StL2:       fan_d = 2'd2;
      StL3: begin
        fan_d  = 2'd3;
        busy_d = 1'b1;
      end
      StCooldown: begin
        fan_d  = 2'd2;
        busy_d = 1'b1;
      end
      StClean: begin
        clean_d = 1'b1;
        busy_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.mode           = state_q;
  assign bus.fan_level      = fan_q;
  assign bus.clean_active   = clean_q;
  assign bus.remaining_s    = rem_q;
  assign bus.hurricane_used = hused_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_hood_mode_sequencer.sv
// Directed + randomized bench for hood_mode_sequencer, checked against a
// cycles-since-entry reference model of the mode rules.
module tb_hood_mode_sequencer;

  localparam int unsigned CLK_HZ      = 10;
  localparam int unsigned HURRICANE_S = 3;
  localparam int unsigned COOLDOWN_S  = 2;
  localparam int unsigned CLEAN_S     = 4;

  // key vector order: {menu, level3, level2, level1, clean}
  localparam logic [4:0] K_NONE = 5'b00000;
  localparam logic [4:0] K_MENU = 5'b10000;
  localparam logic [4:0] K_L3   = 5'b01000;
  localparam logic [4:0] K_L2   = 5'b00100;
  localparam logic [4:0] K_L1   = 5'b00010;
  localparam logic [4:0] K_CLN  = 5'b00001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  hood_mode_sequencer_if bus();

  hood_mode_sequencer #(
    .CLK_HZ      (CLK_HZ),
    .HURRICANE_S (HURRICANE_S),
    .COOLDOWN_S  (COOLDOWN_S),
    .CLEAN_S     (CLEAN_S)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: mode number, cycles spent since entering it, hurricane flag
  int m_mode = 0;
  int m_el   = 0;
  bit m_hu   = 1'b0;

  function automatic int dur(input int md);
    case (md)
      4:       return HURRICANE_S;
      5:       return COOLDOWN_S;
      6:       return CLEAN_S;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_el   = 0;
    m_hu   = 1'b0;
  endtask

  task automatic model_step(input logic p, input logic [4:0] k);
    int nm;
    bit expire;
    nm     = m_mode;
    expire = (dur(m_mode) > 0) && (m_el == dur(m_mode) * CLK_HZ - 1);
    if (!p) begin
      nm   = 0;
      m_hu = 1'b0;
    end else begin
      case (m_mode)
        0: nm = 1;
        1, 2, 3: begin
          if (k[4]) nm = (m_mode == 1) ? 1 : 1;
          else if (k[3]) begin
            if (!m_hu) nm = 4;
          end
          else if (k[2]) nm = 3;
          else if (k[1]) nm = 2;
          else if (k[0] && m_mode == 1) nm = 6;
        end
        4: begin
          if (k[4]) nm = 5;
          else if (expire) nm = 3;
        end
        default: if (expire) nm = 1;
      endcase
    end
    if (nm == 4 && m_mode != 4) m_hu = 1'b1;
    if (nm != m_mode) m_el = 0;
    else m_el++;
    m_mode = nm;
  endtask

  task automatic cmp(input string tag, input string fld, input logic [7:0] got,
                     input logic [7:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s %s got %0d want %0d", tag, fld, got, want);
    end
  endtask

  task automatic check(input string tag);
    int fan_tbl [7] = '{0, 0, 1, 2, 3, 2, 0};
    int rem;
    rem = (dur(m_mode) > 0) ? dur(m_mode) - m_el / CLK_HZ : 0;
    cmp(tag, "mode",  {5'd0, bus.mode},            8'(m_mode));
    cmp(tag, "fan",   {6'd0, bus.fan_level},       8'(fan_tbl[m_mode]));
    cmp(tag, "clean", {7'd0, bus.clean_active},    {7'd0, m_mode == 6});
    cmp(tag, "rem",   bus.remaining_s,             8'(rem));
    cmp(tag, "hused", {7'd0, bus.hurricane_used},  {7'd0, m_hu});
    cmp(tag, "busy",  {7'd0, bus.busy},            {7'd0, m_mode >= 4});
  endtask

  task automatic step(input logic p, input logic [4:0] k, input string tag);
    @(negedge clk);
    bus.power_on   = p;
    bus.menu_key   = k[4];
    bus.level3_key = k[3];
    bus.level2_key = k[2];
    bus.level1_key = k[1];
    bus.clean_key  = k[0];
    @(posedge clk);
    model_step(p, k);
    #1;
    {bus.menu_key, bus.level3_key, bus.level2_key, bus.level1_key, bus.clean_key} = '0;
    check(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, K_NONE, tag);
  endtask

  initial begin
    bus.power_on = 1'b0;
    {bus.menu_key, bus.level3_key, bus.level2_key, bus.level1_key, bus.clean_key} = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset");
    @(negedge clk);
    reset = 1'b0;

    // power up, level2, menu
    step(1'b1, K_NONE, "power_up");
    step(1'b1, K_L2,   "standby_l2");
    step(1'b1, K_MENU, "l2_menu");

    // hurricane runs to expiry, second request ignored
    step(1'b1, K_L3,   "hurricane_entry");
    idle(30, "hurricane_run");
    step(1'b1, K_L3,   "hurricane_reuse");
    step(1'b1, K_MENU, "back_standby");

    // power cycle, hurricane exited by menu at remaining 2 -> cooldown
    step(1'b0, K_NONE, "power_drop1");
    step(1'b1, K_NONE, "power_up1");
    step(1'b1, K_L3,   "hurricane2");
    idle(10, "hurricane2_run");
    step(1'b1, K_MENU, "cooldown_entry");
    step(1'b1, K_L1,   "cooldown_l1_ign");
    step(1'b1, K_MENU, "cooldown_menu_ign");
    idle(18, "cooldown_run");
    step(1'b0, K_NONE, "power_drop2");
    step(1'b1, K_NONE, "power_up2");
    step(1'b1, K_L3,   "hurricane_again");
    step(1'b1, K_MENU, "cooldown2");
    idle(20, "cooldown2_run");

    // self-clean
    step(1'b1, K_CLN,  "clean_entry");
    step(1'b1, K_L1,   "clean_l1_ign");
    idle(39, "clean_run");

    // simultaneous keys
    step(1'b0, K_NONE, "power_drop3");
    step(1'b1, K_NONE, "power_up3");
    step(1'b1, K_L1 | K_L3, "l1_l3_same");
    step(1'b1, K_MENU, "to_cooldown3");
    idle(20, "cooldown3_run");
    step(1'b1, K_L1,   "standby_l1");
    step(1'b1, K_MENU | K_L2, "menu_l2_same");

    // power drop mid clean
    step(1'b1, K_CLN,  "clean2_entry");
    idle(20, "clean2_run");
    step(1'b0, K_NONE, "clean_power_drop");

    // async reset mid hurricane
    step(1'b1, K_NONE, "power_up4");
    step(1'b1, K_L3,   "hurricane3");
    idle(5, "hurricane3_run");
    #2;
    reset = 1'b1;
    bus.power_on = 1'b0;
    model_reset();
    #1;
    check("async_reset");
    @(negedge clk);
    reset = 1'b0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic       p;
      logic [4:0] k;
      p = ($urandom_range(99) >= 3);
      for (int b = 0; b < 5; b++) k[b] = ($urandom_range(11) == 0);
      step(p, k, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hood_mode_sequencer.md
Name: hood_mode_sequencer

Overview:
- Sequences the range-hood fan and self-clean function once the gesture/power controller has turned the appliance on.
- Consumes the registered power flag plus debounced single-cycle key pulses, and runs one mode state machine with a 1 s timebase for the timed modes (hurricane, cooldown, self-clean).
- Drives the fan-level and clean outputs, and the remaining-seconds value used by the display block.

Parameters:
- CLK_HZ, 100_000_000: clk cycles per 1 s tick.
- HURRICANE_S, 60: hurricane (level-3) run time, seconds.
- COOLDOWN_S, 60: forced level-2 run after hurricane is exited by menu, seconds.
- CLEAN_S, 180: self-clean duration, seconds.
- All *_S values are 1..255 (8-bit counter).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- power_on  in  1  level from power controller; 1 = appliance on
- menu_key  in  1  single-cycle pulse; return to standby / exit hurricane
- level1_key  in  1  single-cycle pulse
- level2_key  in  1  single-cycle pulse
- level3_key  in  1  single-cycle pulse; hurricane request
- clean_key  in  1  single-cycle pulse; self-clean request
- mode  out  3  0 OFF, 1 STANDBY, 2 L1, 3 L2, 4 L3, 5 COOLDOWN, 6 CLEAN
- fan_level  out  2  0..3 fan speed
- clean_active  out  1  high only in CLEAN
- remaining_s  out  8  seconds left in a timed mode, else 0
- hurricane_used  out  1  hurricane already consumed this power cycle
- busy  out  1  high in L3, COOLDOWN, CLEAN

Behaviour:
- Reset is asynchronous, active-high, on clk. On reset: mode=OFF; fan_level=0; clean_active=0; remaining_s=0; hurricane_used=0; busy=0; prescaler=0.
- All outputs are registered. Effect of any input is visible the cycle after it is sampled (1-cycle latency).
- fan_level by state: OFF 0, STANDBY 0, L1 1, L2 2, L3 3, COOLDOWN 2, CLEAN 0.
- power_on=0 in any state -> OFF next cycle, with remaining_s=0 and hurricane_used=0. This has the highest priority, above keys and expiry.
- OFF with power_on=1 -> STANDBY.
- Key priority when several pulses arrive in the same cycle: menu > level3 > level2 > level1 > clean. Only the highest-priority key is acted on.
- STANDBY:
  - level1 -> L1.
  - level2 -> L2.
  - level3 -> L3, only if hurricane_used=0; otherwise ignored and the state stays STANDBY.
  - clean -> CLEAN.
  - menu has no effect.
- L1 / L2:
  - level1/level2 switch directly between L1 and L2.
  - level3 -> L3 if hurricane_used=0, else ignored.
  - menu -> STANDBY.
  - clean is ignored.
- L3:
  - Entry loads remaining_s=HURRICANE_S and sets hurricane_used=1.
  - Expiry -> L2.
  - menu -> COOLDOWN.
  - All other keys are ignored.
- COOLDOWN:
  - Entry loads COOLDOWN_S.
  - All keys are ignored.
  - Expiry -> STANDBY.
- CLEAN:
  - Entry loads CLEAN_S.
  - All keys are ignored.
  - Expiry -> STANDBY.
- Timebase:
  - Prescaler counts 0..CLK_HZ-1 and is cleared on entry to every timed state.
  - A tick occurs when the prescaler wraps.
  - On a tick: if remaining_s>1, decrement; if remaining_s==1, take the expiry transition and set remaining_s=0 (or reload for the next timed state).
  - Time spent in a timed state = N*CLK_HZ cycles after entry.
- Non-timed states hold remaining_s=0. Prescaler is don't-care there.
- Expiry and menu in the same cycle in L3: menu wins (-> COOLDOWN).
- Expiry and power_on=0 in the same cycle: OFF.
- Key pulses while power_on=0 are ignored.
- Illegal mode encoding -> OFF next cycle.

Test Plan (CLK_HZ=10, HURRICANE_S=3, COOLDOWN_S=2, CLEAN_S=4):
- Reset, then power_on=1 -> mode 1 one cycle later. Then level2_key -> mode 3, fan_level 2. Then menu_key -> mode 1, fan_level 0.
- STANDBY, level3_key -> mode 4, fan_level 3, remaining_s 3, hurricane_used 1, busy 1. remaining_s steps 3,2,1 every 10 cycles. 30 cycles after entry -> mode 3, remaining_s 0. A second level3_key is ignored (mode stays 3).
- L3, menu_key at remaining_s=2 -> mode 5, fan_level 2, remaining_s 2. Keys are ignored. After 20 cycles -> mode 1. Then drop power_on and raise it again -> hurricane_used 0, and level3_key is accepted again.
- STANDBY, clean_key -> mode 6, clean_active 1, fan_level 0. level1_key is ignored. After 40 cycles -> mode 1, clean_active 0.
- STANDBY, level1_key+level3_key in the same cycle -> mode 4. menu_key+level2_key in the same cycle while in L1 -> mode 1.
- CLEAN with power_on dropped at remaining_s=2 -> mode 0, all outputs 0 next cycle. Async reset asserted mid-L3 -> all outputs 0 immediately, without waiting for a clk edge.
